// File: rtl/cache_control_pkg.sv
// Shared types for the cache miss sequencer.
package cache_control_pkg;

    typedef enum logic [1:0] {
        CC_IDLE,
        CC_WRITEBACK,
        CC_ALLOCATE
    } cache_state_t;

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] count
);

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Write-back / write-allocate miss sequencer for the 2-way cache datapath,
// with saturating hit, miss and writeback performance counters.
module cache_control
    import cache_control_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 mem_resp,
    input  logic                 hit,
    input  logic                 dirty,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 sel_way_mux,
    output logic                 pmem_mux_sel,
    input  logic                 clear_counters,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    cache_state_t state_q;
    cache_state_t state_d;
    logic         miss_flag_q;
    logic         miss_flag_d;
    logic         mem_resp_q;
    logic         request;
    logic         miss_start;
    logic         completion;
    logic         hit_inc;
    logic         wb_inc;

    assign request    = mem_read | mem_write;
    assign miss_start = (state_q == CC_IDLE) & request & ~hit;
    assign completion = mem_resp & ~mem_resp_q;
    assign hit_inc    = completion & ~miss_flag_q;
    assign wb_inc     = miss_start & dirty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once a physical transaction starts it always runs to pmem_resp,
    // even if the CPU request goes away.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CC_IDLE: begin
                if (miss_start) begin
                    state_d = dirty ? CC_WRITEBACK : CC_ALLOCATE;
                end
            end
            CC_WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = CC_ALLOCATE;
                end
            end
            CC_ALLOCATE: begin
                if (pmem_resp) begin
                    state_d = CC_IDLE;
                end
            end
            default: state_d = CC_IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        sel_way_mux  = 1'b0;
        pmem_mux_sel = 1'b0;
        unique case (state_q)
            CC_WRITEBACK: begin
                pmem_write   = 1'b1;
                sel_way_mux  = 1'b1;
                pmem_mux_sel = 1'b1;
            end
            CC_ALLOCATE: begin
                pmem_read   = 1'b1;
                sel_way_mux = 1'b1;
            end
            default: ;
        endcase
    end

    // A new miss takes priority over clearing, so a miss can never be lost.
    always_comb begin
        miss_flag_d = miss_flag_q;
        if (miss_start) begin
            miss_flag_d = 1'b1;
        end else if (completion) begin
            miss_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_flag_q <= 1'b0;
            mem_resp_q  <= 1'b0;
        end else begin
            miss_flag_q <= miss_flag_d;
            mem_resp_q  <= mem_resp;
        end
    end

    sat_counter #(.width(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_inc),
        .clr   (clear_counters),
        .count (hit_count)
    );

    sat_counter #(.width(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_start),
        .clr   (clear_counters),
        .count (miss_count)
    );

    sat_counter #(.width(CNT_WIDTH)) u_wb_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wb_inc),
        .clr   (clear_counters),
        .count (wb_count)
    );

endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control: the driver predicts pmem
// bursts and counter values; a negedge monitor pops and compares them.
module tb_cache_control;

    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_read, mem_write, mem_resp, hit, dirty, pmem_resp;
    logic          pmem_read, pmem_write, sel_way_mux, pmem_mux_sel;
    logic          clear_counters;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_resp       (mem_resp),
        .hit            (hit),
        .dirty          (dirty),
        .pmem_resp      (pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .sel_way_mux    (sel_way_mux),
        .pmem_mux_sel   (pmem_mux_sel),
        .clear_counters (clear_counters),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .wb_count       (wb_count)
    );

    always #5 clk = ~clk;

    // kind: 1 = physical read (refill), 2 = physical write (writeback)
    typedef struct {int kind; int len;} burst_t;
    typedef struct {int h; int m; int w;} cnt_t;

    burst_t burst_q[$];
    cnt_t   cnt_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: counts plus "last access missed" flag.
    int  m_hit = 0, m_miss = 0, m_wb = 0;
    bit  m_pending = 0;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hit = 0; m_miss = 0; m_wb = 0; m_pending = 0;
    endtask

    // One-cycle mem_resp pulse; a completion either counts a hit or retires a miss.
    task automatic complete(input bit clr);
        cnt_t c;
        if (clr) begin
            m_hit = 0; m_miss = 0; m_wb = 0;
        end else if (!m_pending) begin
            m_hit = sat(m_hit + 1);
        end
        m_pending = 0;
        c.h = m_hit; c.m = m_miss; c.w = m_wb;
        cnt_q.push_back(c);
        mem_resp = 1'b1;
        clear_counters = clr;
        tick();
        mem_resp = 1'b0;
        clear_counters = 1'b0;
    endtask

    task automatic do_hit(input logic rd, input logic wr);
        mem_read = rd; mem_write = wr; hit = 1'b1;
        tick();
        complete(1'b0);
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
    endtask

    task automatic fast_hit();
        mem_read = 1'b1; hit = 1'b1;
        complete(1'b0);
        tick();
    endtask

    task automatic do_miss(input logic rd, input logic wr, input logic d,
                           input int nw, input int na, input bit drop);
        burst_t b;
        mem_read = rd; mem_write = wr; hit = 1'b0; dirty = d;
        m_miss = sat(m_miss + 1);
        if (d) m_wb = sat(m_wb + 1);
        m_pending = 1;
        if (d) begin
            b.kind = 2; b.len = nw;
            burst_q.push_back(b);
        end
        b.kind = 1; b.len = na;
        burst_q.push_back(b);
        tick();
        if (d) begin
            for (int i = 1; i <= nw; i++) begin
                pmem_resp = (i == nw);
                tick();
            end
        end
        for (int i = 1; i <= na; i++) begin
            if (drop && i == 1) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
            pmem_resp = (i == na);
            if (i == na) hit = 1'b1;
            tick();
        end
        pmem_resp = 1'b0;
        if (!drop) begin
            tick();
            complete(1'b0);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
    endtask

    task automatic stray_resp();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
    endtask

    // Monitor: Moore output consistency each cycle, burst lengths, counters after completion.
    initial begin
        int     kind_cur = 0;
        int     len_cur  = 0;
        int     kind;
        logic   mr1 = 1'b0, mr2 = 1'b0;
        burst_t b;
        cnt_t   c;
        forever begin
            @(negedge clk);
            check("both_req", int'(pmem_read & pmem_write), 0);
            kind = pmem_write ? 2 : (pmem_read ? 1 : 0);
            if (kind == 2)      check("mux_wb",   int'({sel_way_mux, pmem_mux_sel}), 3);
            else if (kind == 1) check("mux_alloc", int'({sel_way_mux, pmem_mux_sel}), 2);
            else                check("mux_idle", int'({sel_way_mux, pmem_mux_sel}), 0);
            if (kind != kind_cur) begin
                if (kind_cur != 0) begin
                    if (burst_q.size() == 0) begin
                        check("unexpected_burst", kind_cur, 0);
                    end else begin
                        b = burst_q.pop_front();
                        check("burst_kind", kind_cur, b.kind);
                        check("burst_len", len_cur, b.len);
                    end
                end
                kind_cur = kind;
                len_cur  = (kind != 0) ? 1 : 0;
            end else if (kind != 0) begin
                len_cur++;
            end
            if (mr1 && !mr2) begin
                if (cnt_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    c = cnt_q.pop_front();
                    check("hit_count", int'(hit_count), c.h);
                    check("miss_count", int'(miss_count), c.m);
                    check("wb_count", int'(wb_count), c.w);
                end
            end
            mr2 = mr1;
            mr1 = mem_resp;
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_resp = 1'b0; hit = 1'b0;
        dirty = 1'b0; pmem_resp = 1'b0; clear_counters = 1'b0;
        tick();
        tick();
        check("rst_pmem", int'({pmem_read, pmem_write, sel_way_mux, pmem_mux_sel}), 0);
        check("rst_hit", int'(hit_count), 0);
        check("rst_miss", int'(miss_count), 0);
        check("rst_wb", int'(wb_count), 0);
        reset = 1'b0;
        tick();

        do_hit(1'b1, 1'b0);
        do_miss(1'b1, 1'b0, 1'b0, 1, 3, 1'b0);
        do_miss(1'b0, 1'b1, 1'b1, 2, 2, 1'b0);
        do_miss(1'b1, 1'b0, 1'b0, 1, 2, 1'b1);
        stray_resp();
        do_hit(1'b1, 1'b1);
        do_hit(1'b0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 3);
            if (n == 0) begin
                do_hit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b0);
            end else begin
                int rw = $urandom_range(1, 3);
                do_miss(rw[0], rw[1], n[0], $urandom_range(1, 4), $urandom_range(1, 4),
                        ($urandom_range(0, 5) == 0));
            end
            if ($urandom_range(0, 3) == 0) stray_resp();
        end

        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        model_reset();
        for (int i = 0; i < (1 << CW) + 3; i++) fast_hit();
        mem_read = 1'b1; hit = 1'b1;
        complete(1'b1);
        mem_read = 1'b0;
        tick();

        do_miss(1'b1, 1'b0, 1'b1, 1, 1, 1'b0);
        mem_write = 1'b1; hit = 1'b0; dirty = 1'b1;
        begin
            burst_t b;
            b.kind = 2; b.len = 2;
            burst_q.push_back(b);
        end
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pmem_write", int'(pmem_write), 0);
        check("async_rst_mux", int'({sel_way_mux, pmem_mux_sel}), 0);
        check("async_rst_hit", int'(hit_count), 0);
        check("async_rst_miss", int'(miss_count), 0);
        check("async_rst_wb", int'(wb_count), 0);
        mem_write = 1'b0; dirty = 1'b0;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        do_hit(1'b1, 1'b0);

        tick();
        tick();
        check("bursts_left", burst_q.size(), 0);
        check("counts_left", cnt_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
